// File: rtl/cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// cla_pipe_adder
//   Three-stage pipelined carry-lookahead adder/subtractor with a valid/ready
//   handshake on both sides. Carries are formed in two levels: 4-bit groups
//   produce group propagate/generate, a lookahead chain across the groups
//   yields each group's carry-in, and the final stage ripples inside each
//   4-bit group seeded by that group carry.
//
//   Stage 1 : operand conditioning (B inverted for subtract), bit P/G.
//   Stage 2 : group PG/GG and group carries Cg[0..NG].
//   Stage 3 : in-group carries, sum, carry out, signed overflow, zero flag.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        synchronous reset, active-high
//   in_valid   operand beat valid
//   in_ready   block can accept an operand beat this cycle
//   in_a       operand A
//   in_b       operand B
//   in_cin     carry in (add only)
//   in_sub     0: sum = A + B + cin ; 1: sum = A - B (cin ignored)
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   out_sum    result, modulo 2^WIDTH
//   out_cout   carry out of the MSB (subtract: 1 = no borrow)
//   out_ovf    signed overflow (carry into MSB xor carry out of MSB)
//   out_zero   out_sum == 0
// ---------------------------------------------------------------------------
module cla_pipe_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NG = WIDTH / 4;

    if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_width_check
        $error("cla_pipe_adder: WIDTH must be a multiple of 4 in the range 4..64");
    end

    // -----------------------------------------------------------------------
    // Pipeline control: a stage advances when it is empty or the stage after
    // it advances, so bubbles collapse and an empty stage always accepts.
    // -----------------------------------------------------------------------
    logic v1, v2, v3;
    logic adv1, adv2, adv3;

    assign adv3      = !v3 || out_ready;
    assign adv2      = !v2 || adv3;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v3;

    // -----------------------------------------------------------------------
    // Stage 1: subtract is A + ~B + 1, so the inversion and forced carry-in
    // are applied here and the rest of the pipe only ever adds.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] bx;
    logic             c0_in;
    logic [WIDTH-1:0] p1, g1;
    logic             c01;

    assign bx    = in_sub ? ~in_b : in_b;
    assign c0_in = in_sub ? 1'b1 : in_cin;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of the others; = here would chain stages within one edge.
    always_ff @(posedge clk) begin
        // NOTE: the data registers are reset as well as the valid bits so the
        // result outputs read zero after reset rather than stale operands.
        if (rst) begin
            v1  <= 1'b0;
            p1  <= '0;
            g1  <= '0;
            c01 <= 1'b0;
        end else if (adv1) begin
            v1  <= in_valid;
            p1  <= in_a ^ bx;
            g1  <= in_a & bx;
            c01 <= c0_in;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: group lookahead. Cg[k] is the carry into group k; Cg[NG] is
    // the carry out of the whole word.
    // -----------------------------------------------------------------------
    logic [NG-1:0] pg, gg;
    logic [NG:0]   cg;

    // NOTE: every variable written in always_comb gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        pg    = '0;
        gg    = '0;
        cg    = '0;
        cg[0] = c01;
        for (int k = 0; k < NG; k++) begin
            pg[k]   = &p1[4*k +: 4];
            gg[k]   = g1[4*k+3]
                    | (g1[4*k+2] & p1[4*k+3])
                    | (g1[4*k+1] & p1[4*k+3] & p1[4*k+2])
                    | (g1[4*k]   & p1[4*k+3] & p1[4*k+2] & p1[4*k+1]);
            cg[k+1] = gg[k] | (pg[k] & cg[k]);
        end
    end

    logic [WIDTH-1:0] p2, g2;
    logic [NG:0]      cg2;

    always_ff @(posedge clk) begin
        if (rst) begin
            v2  <= 1'b0;
            p2  <= '0;
            g2  <= '0;
            cg2 <= '0;
        end else if (adv2) begin
            v2  <= v1;
            p2  <= p1;
            g2  <= g1;
            cg2 <= cg;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 3: ripple the three inner carries of each group from its group
    // carry. The carry out of each group's MSB is already known as the next
    // group carry, so c[WIDTH] is taken from the lookahead chain directly.
    // -----------------------------------------------------------------------
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_nxt;

    always_comb begin
        c = '0;
        for (int k = 0; k < NG; k++) begin
            c[4*k] = cg2[k];
            for (int j = 0; j < 3; j++) begin
                c[4*k+j+1] = g2[4*k+j] | (p2[4*k+j] & c[4*k+j]);
            end
        end
        c[WIDTH] = cg2[NG];
    end

    assign sum_nxt = p2 ^ c[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            v3       <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
        end else if (adv3) begin
            v3       <= v2;
            out_sum  <= sum_nxt;
            out_cout <= c[WIDTH];
            out_ovf  <= c[WIDTH] ^ c[WIDTH-1];
            out_zero <= (sum_nxt == '0);
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_pipe_adder
//   Self-checking bench for cla_pipe_adder. Three instances (WIDTH 16, 4, 64)
//   share the stimulus bus; sel picks which one receives in_valid and whose
//   outputs are observed. Accepted beats push a model result onto a
//   scoreboard queue, delivered results pop and compare in order.
// ---------------------------------------------------------------------------
module tb_cla_pipe_adder;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic [63:0] in_a, in_b;
    logic        in_cin, in_sub;
    logic        out_ready;
    logic        rand_ready;
    logic [1:0]  sel;

    logic        rdy16, val16, cout16, ovf16, zero16;
    logic [15:0] sum16;
    logic        rdy4, val4, cout4, ovf4, zero4;
    logic [3:0]  sum4;
    logic        rdy64, val64, cout64, ovf64, zero64;
    logic [63:0] sum64;

    cla_pipe_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && sel == 2'd0), .in_ready(rdy16),
        .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(val16), .out_ready(out_ready),
        .out_sum(sum16), .out_cout(cout16), .out_ovf(ovf16), .out_zero(zero16)
    );

    cla_pipe_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && sel == 2'd1), .in_ready(rdy4),
        .in_a(in_a[3:0]), .in_b(in_b[3:0]), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(val4), .out_ready(out_ready),
        .out_sum(sum4), .out_cout(cout4), .out_ovf(ovf4), .out_zero(zero4)
    );

    cla_pipe_adder #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && sel == 2'd2), .in_ready(rdy64),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(val64), .out_ready(out_ready),
        .out_sum(sum64), .out_cout(cout64), .out_ovf(ovf64), .out_zero(zero64)
    );

    // Observed view of the selected instance
    logic        m_ready, m_valid, m_cout, m_ovf, m_zero;
    logic [63:0] m_sum;
    int          cur_w;

    always_comb begin
        m_ready = rdy16;
        m_valid = val16;
        m_sum   = {48'd0, sum16};
        m_cout  = cout16;
        m_ovf   = ovf16;
        m_zero  = zero16;
        cur_w   = 16;
        case (sel)
            2'd1: begin
                m_ready = rdy4;  m_valid = val4;  m_sum = {60'd0, sum4};
                m_cout  = cout4; m_ovf   = ovf4;  m_zero = zero4;  cur_w = 4;
            end
            2'd2: begin
                m_ready = rdy64;  m_valid = val64; m_sum = sum64;
                m_cout  = cout64; m_ovf   = ovf64; m_zero = zero64; cur_w = 64;
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Reference model: plain wide addition, overflow from operand/result signs
    // -----------------------------------------------------------------------
    function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub);
        res_t        r;
        logic [64:0] mask, aa, bb, full;
        mask   = (65'd1 << w) - 65'd1;
        aa     = {1'b0, a} & mask;
        bb     = {1'b0, (sub ? ~b : b)} & mask;
        full   = aa + bb + {64'd0, (sub ? 1'b1 : cin)};
        r.sum  = full[63:0] & mask[63:0];
        r.cout = full[w];
        r.ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
        r.zero = (r.sum == 64'd0);
        return r;
    endfunction

    res_t sb[$];
    int   checks = 0;
    int   failures = 0;

    logic last_accept, last_fire, prev_stall;
    res_t obs, prev;
    int   run_len, max_run, fire_count;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called once per cycle at the falling edge: inputs and out_ready hold the
    // values the next rising edge will see.
    task automatic sample();
        res_t e, cur;
        last_accept = 1'b0;
        last_fire   = 1'b0;
        cur.sum  = m_sum;
        cur.cout = m_cout;
        cur.ovf  = m_ovf;
        cur.zero = m_zero;
        if (rst) begin
            sb.delete();
            prev_stall = 1'b0;
            run_len    = 0;
            prev       = cur;
            return;
        end
        if (prev_stall) begin
            check("hold_valid", {63'd0, m_valid}, 64'd1);
            check("hold_sum", cur.sum, prev.sum);
            check("hold_flags", {61'd0, cur.cout, cur.ovf, cur.zero},
                  {61'd0, prev.cout, prev.ovf, prev.zero});
        end
        if (in_valid && m_ready) begin
            sb.push_back(model(cur_w, in_a, in_b, in_cin, in_sub));
            last_accept = 1'b1;
        end
        if (m_valid && out_ready) begin
            last_fire = 1'b1;
            fire_count++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            obs = cur;
            if (sb.size() == 0) begin
                check("unexpected_out", {63'd0, m_valid}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("sum", cur.sum, e.sum);
                check("flags", {61'd0, cur.cout, cur.ovf, cur.zero},
                      {61'd0, e.cout, e.ovf, e.zero});
            end
        end else begin
            run_len = 0;
        end
        prev_stall = m_valid && !out_ready;
        prev       = cur;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input logic sub, output int n);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_accept && n < 100);
        if (!last_accept) check("accept_timeout", {63'd0, last_accept}, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_fire && n < 50);
        check("out_seen", {63'd0, last_fire}, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int n, fc;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        out_ready = 1'b1; rand_ready = 1'b0; sel = 2'd0;
        prev_stall = 1'b0; run_len = 0; max_run = 0; fire_count = 0;
        last_accept = 1'b0; last_fire = 1'b0; obs = '0; prev = '0;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        check("rst_out_valid", {63'd0, m_valid}, 64'd0);
        check("rst_sum", m_sum, 64'd0);
        check("rst_flags", {61'd0, m_cout, m_ovf, m_zero}, 64'd0);
        check("rst_in_ready", {63'd0, m_ready}, 64'd1);

        // W=16 add wrap to zero, latency exactly 3 cycles
        drive(64'hFFFF, 64'h0001, 1'b0, 1'b0, n);
        wait_out(n);
        check("latency", 64'(n), 64'd3);
        check("add_wrap_sum", obs.sum, 64'h0000);
        check("add_wrap_cz", {62'd0, obs.cout, obs.zero}, 64'b11);
        check("add_wrap_ovf", {63'd0, obs.ovf}, 64'd0);

        // W=16 subtracts
        drive(64'h8000, 64'h0001, 1'b1, 1'b1, n);
        wait_out(n);
        check("sub1_sum", obs.sum, 64'h7FFF);
        check("sub1_cout_ovf", {62'd0, obs.cout, obs.ovf}, 64'b11);
        drive(64'h0003, 64'h0005, 1'b0, 1'b1, n);
        wait_out(n);
        check("sub2_sum", obs.sum, 64'hFFFE);
        check("sub2_cout_ovf", {62'd0, obs.cout, obs.ovf}, 64'b00);

        // Back-to-back 8 beats
        max_run = 0;
        for (int i = 0; i < 8; i++) begin
            drive(64'(i * 16'h1111), 64'(16'h0F0F + i), i[0], i[1], n);
            check("b2b_accept_cycles", 64'(n), 64'd1);
        end
        drain();
        check("b2b_run", 64'(max_run), 64'd8);

        // Stall with 3 beats in flight
        out_ready = 1'b0;
        drive(64'h1234, 64'h4321, 1'b0, 1'b0, n);
        drive(64'h7FFF, 64'h0001, 1'b0, 1'b0, n);
        drive(64'h0000, 64'h0001, 1'b0, 1'b1, n);
        in_a = 64'hAAAA; in_b = 64'h5555; in_cin = 1'b1; in_sub = 1'b0; in_valid = 1'b1;
        repeat (4) begin
            tick();
            check("stall_no_accept", {63'd0, last_accept}, 64'd0);
        end
        check("stall_in_ready", {63'd0, m_ready}, 64'd0);
        out_ready = 1'b1;
        drive(64'hAAAA, 64'h5555, 1'b1, 1'b0, n);
        drain();

        // Reset with 2 beats in flight
        drive(64'h0101, 64'h0202, 1'b0, 1'b0, n);
        drive(64'h0303, 64'h0404, 1'b0, 1'b0, n);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", {63'd0, m_valid}, 64'd0);
        check("midrst_sum", m_sum, 64'd0);
        check("midrst_flags", {61'd0, m_cout, m_ovf, m_zero}, 64'd0);
        fc = fire_count;
        repeat (8) tick();
        check("midrst_no_stale", 64'(fire_count - fc), 64'd0);

        // W=4: directed cin add, then random
        sel = 2'd1;
        drive(64'h7, 64'h8, 1'b1, 1'b0, n);
        wait_out(n);
        check("w4_sum", obs.sum, 64'h0);
        check("w4_cout", {63'd0, obs.cout}, 64'd1);
        rand_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), n);
        end
        rand_ready = 1'b0; out_ready = 1'b1;
        drain();

        // W=64: directed full-width wrap, then random
        sel = 2'd2;
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, n);
        wait_out(n);
        check("w64_sum", obs.sum, 64'h0);
        check("w64_cz", {62'd0, obs.cout, obs.zero}, 64'b11);
        rand_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), n);
        end
        rand_ready = 1'b0; out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
